idecoder_fifo: RTL and testbench

- Parametrised decode stage between instruction fetch and the datapath controller.
- Each accepted 16-bit instruction is decoded at write time into opcode, op, shift_op, sign-extended immediates and all three register addresses (Rn, Rd, Rm, exposed separately instead of muxed).
- Decoded instructions are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides. Fetch can therefore run ahead of a multi-cycle controller.

---
 rtl/idecoder_fifo.sv | 127 ++++++++++++
 tb/tb_idecoder_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idecoder_fifo.sv
// Instruction decode FIFO: decodes each 16-bit instruction at push time and buffers the decoded record.
// Latency: one edge from push to head visibility; no same-cycle pass-through.
// Backpressure: in_ready drops when DEPTH entries are held; a pop frees a slot only from the next cycle.
// Optional IDEC_ILLEGAL_EN adds a per-entry 'illegal' flag output.
module idecoder_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       ir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift_op,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [2:0]        rm,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [CNT_W-1:0]  count
`ifdef IDEC_ILLEGAL_EN
  ,
  output logic              illegal
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [1:0]        shift_op;
    logic [2:0]        rn;
    logic [2:0]        rd;
    logic [2:0]        rm;
    logic [DATA_W-1:0] sximm5;
    logic [DATA_W-1:0] sximm8;
`ifdef IDEC_ILLEGAL_EN
    logic              illegal;
`endif
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             wr_rec;
  rec_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  assign in_ready  = (cnt < CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign count     = cnt;

  // Flush wins over both handshakes, so the word presented alongside it is dropped.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Decode the incoming word so the stored record is ready to drive outputs directly.
  always_comb begin
    wr_rec          = '0;
    wr_rec.opcode   = ir[15:13];
    wr_rec.op       = ir[12:11];
    wr_rec.shift_op = ir[4:3];
    wr_rec.rn       = ir[10:8];
    wr_rec.rd       = ir[7:5];
    wr_rec.rm       = ir[2:0];
    wr_rec.sximm5   = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    wr_rec.sximm8   = {{(DATA_W-8){ir[7]}}, ir[7:0]};
`ifdef IDEC_ILLEGAL_EN
    wr_rec.illegal  = (ir[15:13] == 3'b000) ||
                      (((ir[15:13] == 3'b011) || (ir[15:13] == 3'b100)) && (ir[12:11] != 2'b00));
`endif
  end

  // Storage needs no reset: outputs are gated by out_valid, which reset clears.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Present the head record only while an entry is held; otherwise drive zeros.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign opcode   = head.opcode;
  assign op       = head.op;
  assign shift_op = head.shift_op;
  assign rn       = head.rn;
  assign rd       = head.rd;
  assign rm       = head.rm;
  assign sximm5   = head.sximm5;
  assign sximm8   = head.sximm8;
`ifdef IDEC_ILLEGAL_EN
  assign illegal  = head.illegal;
`endif

endmodule

// File: tb/tb_idecoder_fifo.sv
// Self-checking bench for idecoder_fifo with a scoreboard of accepted instruction words.
module tb_idecoder_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       ir;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [1:0]        shift_op;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [2:0]        rm;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] sximm8;
  logic [CNT_W-1:0]  count;
`ifdef IDEC_ILLEGAL_EN
  logic              illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb_q[$];

  idecoder_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .op(op), .shift_op(shift_op),
    .rn(rn), .rd(rd), .rm(rm),
    .sximm5(sximm5), .sximm8(sximm8), .count(count)
`ifdef IDEC_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] sx5(input logic [15:0] w);
    return {{(DATA_W-5){w[4]}}, w[4:0]};
  endfunction

  function automatic logic [DATA_W-1:0] sx8(input logic [15:0] w);
    return {{(DATA_W-8){w[7]}}, w[7:0]};
  endfunction

`ifdef IDEC_ILLEGAL_EN
  function automatic logic exp_illegal(input logic [15:0] w);
    return (w[15:13] == 3'b000) ||
           (((w[15:13] == 3'b011) || (w[15:13] == 3'b100)) && (w[12:11] != 2'b00));
  endfunction
`endif

  // Scoreboard monitor: checks state against the model, then applies this cycle's handshakes.
  always @(negedge clk) begin
    logic [15:0] w;
    if (rst) begin
      sb_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_outputs", {opcode, op, shift_op, rn, rd, rm, sximm5, sximm8}, 0);
    end else begin
      check("count", count, sb_q.size());
      check("out_valid", out_valid, sb_q.size() != 0);
      check("in_ready", in_ready, sb_q.size() < DEPTH);
      if (!out_valid) begin
        check("idle_zero", {opcode, op, shift_op, rn, rd, rm, sximm5, sximm8}, 0);
`ifdef IDEC_ILLEGAL_EN
        check("idle_illegal", illegal, 0);
`endif
      end else if (sb_q.size() != 0) begin
        w = sb_q[0];
        check("head_opcode", opcode, w[15:13]);
        check("head_op", op, w[12:11]);
        check("head_shift", shift_op, w[4:3]);
        check("head_rn", rn, w[10:8]);
        check("head_rd", rd, w[7:5]);
        check("head_rm", rm, w[2:0]);
        check("head_sximm5", sximm5, sx5(w));
        check("head_sximm8", sximm8, sx8(w));
`ifdef IDEC_ILLEGAL_EN
        check("head_illegal", illegal, exp_illegal(w));
`endif
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
        if (in_valid && in_ready) sb_q.push_back(ir);
      end
    end
  end

  // Present a word and hold it until the DUT accepts it.
  task automatic push_word(input logic [15:0] w);
    int n = 0;
    ir = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Pop everything held, bounded.
  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (count != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", 1, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    ir = 16'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_count", count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic decode into empty FIFO
    push_word(16'hA143);
    check("t1_valid", out_valid, 1);
    check("t1_opcode", opcode, 3'b101);
    check("t1_op", op, 2'b00);
    check("t1_rn", rn, 3'd1);
    check("t1_rd", rd, 3'd2);
    check("t1_rm", rm, 3'd3);
    check("t1_shift", shift_op, 2'b00);
    check("t1_sximm5", sximm5, 16'h0003);
    check("t1_sximm8", sximm8, 16'h0043);
    check("t1_count", count, 1);
    drain();

    // Negative immediates
    push_word(16'hD0FF);
    check("t2_sximm8", sximm8, 16'hFFFF);
    check("t2_sximm5", sximm5, 16'hFFFF);
    check("t2_rn", rn, 3'd0);
    check("t2_op", op, 2'b10);
    drain();

    // Fill to capacity, refuse a fifth, then drain in order
    push_word(16'h1111);
    push_word(16'h2A52);
    push_word(16'hC3E7);
    push_word(16'h4C98);
    check("t3_full_count", count, 4);
    check("t3_in_ready", in_ready, 0);
    ir = 16'h5555;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t3_no_accept", count, 4);
    in_valid = 1'b0;
    drain();
    check("t3_empty", count, 0);

    // Continuous streaming across pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(16'h3000 + 16'(i * 16'h0123));
    check("t4_count", count, 1);
    drain();

    // Flush with a simultaneous push
    push_word(16'h6A11);
    push_word(16'hB2F0);
    push_word(16'h8E0D);
    check("t5_count3", count, 3);
    flush = 1'b1;
    ir = 16'hBEEF;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_count0", count, 0);
    check("t5_valid0", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset mid-stream
    push_word(16'hE7A5);
    push_word(16'h2F3C);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t7_rst_valid", out_valid, 0);
    check("t7_rst_count", count, 0);
    check("t7_rst_opcode", opcode, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef IDEC_ILLEGAL_EN
    push_word(16'h0000);
    check("t6_ill0", illegal, 1);
    drain();
    push_word(16'h6800);
    check("t6_ill1", illegal, 1);
    drain();
    push_word(16'hA143);
    check("t6_ill2", illegal, 0);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
